control_sequencer: RTL

SAP-1 controller-sequencer: a six-state ring counter (T1–T6) plus a halt state that generates the per-cycle control word for every datapath block. It sits directly upstream of the program counter, driving its `Cp` (increment) and `Ep` (drive bus) inputs. It also drives the MAR, RAM, IR, accumulator, B register, adder/subtractor and output register. It decodes the IR opcode during the execute states.

---
 rtl/control_sequencer_if.sv | 29 ++
 rtl/control_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Control bus between the SAP-1 sequencer and the datapath blocks it steers.
interface control_sequencer_if;
    logic [3:0] ir_op;
    logic [5:0] t_state;
    logic       Cp;
    logic       Ep;
    logic       Lm;
    logic       CE;
    logic       Li;
    logic       Ei;
    logic       La;
    logic       Ea;
    logic       Su;
    logic       Eu;
    logic       Lb;
    logic       Lo;
    logic       halted;
    logic       instr_done;

    modport master (
        input  ir_op,
        output t_state, Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, halted, instr_done
    );

    modport slave (
        output ir_op,
        input  t_state, Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, halted, instr_done
    );
endinterface

// File: rtl/control_sequencer.sv
// SAP-1 controller-sequencer: T1..T6 ring plus absorbing HALT, with a
// combinational control-word decode of the current T-state and opcode.
module control_sequencer #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input logic                 clk,
    input logic                 rst,
    control_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_T1   = 3'd0,
        ST_T2   = 3'd1,
        ST_T3   = 3'd2,
        ST_T4   = 3'd3,
        ST_T5   = 3'd4,
        ST_T6   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_t;

    state_t     state_r;
    state_t     state_next_s;
    ctrl_t      ctrl_s;
    ctrl_t      ctrl_out_s;
    logic [5:0] t_state_s;
    logic       halted_s;
    logic       done_s;

    // State register; reset forces T1 without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_T1;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and control-word decode.
    always_comb begin
        state_next_s = state_r;
        ctrl_s       = '0;
        t_state_s    = 6'b000000;
        case (state_r)
            ST_T1: begin
                state_next_s = ST_T2;
                t_state_s    = 6'b000001;
                ctrl_s.ep    = 1'b1;
                ctrl_s.lm    = 1'b1;
            end
            ST_T2: begin
                state_next_s = ST_T3;
                t_state_s    = 6'b000010;
                ctrl_s.cp    = 1'b1;
            end
            ST_T3: begin
                state_next_s = ST_T4;
                t_state_s    = 6'b000100;
                ctrl_s.ce    = 1'b1;
                ctrl_s.li    = 1'b1;
            end
            ST_T4: begin
                t_state_s = 6'b001000;
                if (bus.ir_op == OP_HLT) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_T5;
                end
                case (bus.ir_op)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ctrl_s.ei = 1'b1;
                        ctrl_s.lm = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl_s.ea = 1'b1;
                        ctrl_s.lo = 1'b1;
                    end
                    default: ctrl_s = '0;
                endcase
            end
            ST_T5: begin
                state_next_s = ST_T6;
                t_state_s    = 6'b010000;
                case (bus.ir_op)
                    OP_LDA: begin
                        ctrl_s.ce = 1'b1;
                        ctrl_s.la = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl_s.ce = 1'b1;
                        ctrl_s.lb = 1'b1;
                    end
                    default: ctrl_s = '0;
                endcase
            end
            ST_T6: begin
                state_next_s = ST_T1;
                t_state_s    = 6'b100000;
                case (bus.ir_op)
                    OP_ADD: begin
                        ctrl_s.eu = 1'b1;
                        ctrl_s.la = 1'b1;
                    end
                    OP_SUB: begin
                        ctrl_s.su = 1'b1;
                        ctrl_s.eu = 1'b1;
                        ctrl_s.la = 1'b1;
                    end
                    default: ctrl_s = '0;
                endcase
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_T1;
            end
        endcase
    end

    // Hold every strobe low while reset is asserted, even though the ring already reads T1.
    always_comb begin
        if (rst) begin
            ctrl_out_s = ctrl_s;
            halted_s   = (state_r == ST_HALT);
            done_s     = (state_r == ST_T6);
        end else begin
            ctrl_out_s = '0;
            halted_s   = 1'b0;
            done_s     = 1'b0;
        end
    end

    assign bus.t_state    = t_state_s;
    assign bus.Cp         = ctrl_out_s.cp;
    assign bus.Ep         = ctrl_out_s.ep;
    assign bus.Lm         = ctrl_out_s.lm;
    assign bus.CE         = ctrl_out_s.ce;
    assign bus.Li         = ctrl_out_s.li;
    assign bus.Ei         = ctrl_out_s.ei;
    assign bus.La         = ctrl_out_s.la;
    assign bus.Ea         = ctrl_out_s.ea;
    assign bus.Su         = ctrl_out_s.su;
    assign bus.Eu         = ctrl_out_s.eu;
    assign bus.Lb         = ctrl_out_s.lb;
    assign bus.Lo         = ctrl_out_s.lo;
    assign bus.halted     = halted_s;
    assign bus.instr_done = done_s;

endmodule
